// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, RGB565 field layout and frame geometry
// for the OV7670 capture path and the frame-buffer RAM that it fills.
package cam_pkg;

  // Default frame geometry; the frame-buffer RAM is sized from these too.
  localparam int CAM_H_ACTIVE = 160;
  localparam int CAM_V_ACTIVE = 120;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cam_state_t;

  // RGB565 field offsets inside the assembled {first byte, second byte} word.
  localparam int RGB565_R_LSB = 11;
  localparam int RGB565_G_LSB = 5;
  localparam int RGB565_B_LSB = 0;

  // Index of each sensor control line in the synchroniser bank.
  localparam int CTL_PCLK  = 0;
  localparam int CTL_HREF  = 1;
  localparam int CTL_VSYNC = 2;
  localparam int CTL_NUM   = 3;

  // Reduce an RGB565 word to RGB332 (top bits of each channel), zero-extended.
  function automatic logic [15:0] rgb565_to_332(input logic [15:0] w);
    return {8'h00, w[RGB565_R_LSB+2 +: 3], w[RGB565_G_LSB+3 +: 3], w[RGB565_B_LSB+3 +: 2]};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: STAGES-deep synchroniser for one asynchronous sensor line,
// plus one extra delay flop so rise/fall strobes line up with the synced level.
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              dly;

  // Shift the raw input through the chain; dly remembers the previous synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      dly  <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~dly;
  assign fall = ~q & dly;

endmodule

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: captures one OV7670 RGB565 frame into the frame-buffer RAM.
// Sensor pins are oversampled in the clk domain, byte pairs are assembled into
// pixels and written linearly (line*H_ACTIVE + column). Software arms with start
// and polls busy/done/frame_err.
// Build option: define CAM_RGB332_EN to write RGB332 (zero-extended) instead of RGB565.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = CAM_H_ACTIVE,
  parameter int V_ACTIVE    = CAM_V_ACTIVE,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pclk,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  // col must reach H_ACTIVE+1 so an over-long line is distinguishable from a full one.
  localparam int COL_W  = $clog2(H_ACTIVE + 2);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_ACTIVE + 1);
  localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_ACTIVE);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic [CTL_NUM-1:0] ctl_raw, ctl_lvl, ctl_rise, ctl_fall;

  assign ctl_raw[CTL_PCLK]  = cam_pclk;
  assign ctl_raw[CTL_HREF]  = cam_href;
  assign ctl_raw[CTL_VSYNC] = cam_vsync;

  for (genvar g = 0; g < CTL_NUM; g++) begin : g_sync
    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (ctl_raw[g]),
      .q    (ctl_lvl[g]),
      .rise (ctl_rise[g]),
      .fall (ctl_fall[g])
    );
  end

  logic pclk_rise, href_lvl, href_fall, vs_rise, vs_fall;
  assign pclk_rise = ctl_rise[CTL_PCLK];
  assign href_lvl  = ctl_lvl[CTL_HREF];
  assign href_fall = ctl_fall[CTL_HREF];
  assign vs_rise   = ctl_rise[CTL_VSYNC];
  assign vs_fall   = ctl_fall[CTL_VSYNC];

  // Strobes the capture logic has no use for.
  logic unused_ctl;
  assign unused_ctl = ^{ctl_lvl[CTL_PCLK], ctl_fall[CTL_PCLK],
                        ctl_rise[CTL_HREF], ctl_lvl[CTL_VSYNC]};

  // Data takes the same number of flops as the control lines so the byte
  // seen with pclk_rise is the one the sensor presented on that PCLK edge.
  logic [SYNC_STAGES-1:0][7:0] data_pipe;
  logic [7:0]                  byte_s;

  // Plain delay line for the sensor data bus.
  always_ff @(posedge clk) begin
    if (rst) data_pipe <= '0;
    else     data_pipe <= {data_pipe[SYNC_STAGES-2:0], cam_data};
  end

  assign byte_s = data_pipe[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Capture state
  // ---------------------------------------------------------------------------
  cam_state_t        state;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] addr;
  logic              toggle;
  logic [7:0]        hi;

  logic [15:0]       pix_word;
  logic [15:0]       pix_out;
  logic [LINE_W-1:0] line_after;

  assign pix_word = {hi, byte_s};

`ifdef CAM_RGB332_EN
  assign pix_out = rgb565_to_332(pix_word);
`else
  assign pix_out = pix_word;
`endif

  // Line count after this cycle's href fall, so a coincident vsync rise judges
  // the frame with the closing line already counted.
  always_comb begin
    line_after = line;
    if (href_fall && (line != LINE_FULL)) line_after = line + LINE_W'(1);
  end

  // Capture FSM with registered strobes and pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      col       <= '0;
      line      <= '0;
      addr      <= '0;
      toggle    <= 1'b0;
      hi        <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_WAIT_VS;
            busy      <= 1'b1;
            col       <= '0;
            line      <= '0;
            addr      <= '0;
            toggle    <= 1'b0;
            frame_err <= 1'b0;
          end
        end

        // Only a fresh vsync fall starts capture; a frame already underway is skipped.
        ST_WAIT_VS: begin
          if (vs_fall) state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          if (pclk_rise && href_lvl) begin
            if (!toggle) begin
              hi     <= byte_s;
              toggle <= 1'b1;
            end else begin
              toggle <= 1'b0;
              // Excess pixels and lines are dropped so addr never runs past the frame.
              if ((col < COL_FULL) && (line < LINE_FULL)) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= pix_out;
                addr    <= addr + ADDR_W'(1);
              end
              if (col != COL_SAT) col <= col + COL_W'(1);
            end
          end

          // End of line: a dangling byte or wrong pixel count marks the frame bad.
          if (href_fall) begin
            if (toggle || (col != COL_FULL)) frame_err <= 1'b1;
            toggle <= 1'b0;
            col    <= '0;
            line   <= line_after;
          end

          if (vs_rise) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (line_after != LINE_FULL) frame_err <= 1'b1;
          end
        end

        // done was raised on entry; this cycle just returns to IDLE.
        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
